// File: rtl/cpu_logger_pkg.sv
// Shared constants and types for the CPU result logger.
// Record layout is {sum, q}; it goes out on the wire MSB byte first.
package cpu_logger_pkg;

  localparam int RECORD_W      = 64;
  localparam int BYTES_PER_REC = 8;
  localparam int OVF_W         = 16;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

  typedef logic [RECORD_W-1:0] record_t;

  // Index of the last byte of a record, sized for a 3-bit byte counter.
  localparam logic [2:0] LAST_BYTE = 3'(BYTES_PER_REC - 1);

endpackage

// File: rtl/result_fifo.sv
// Synchronous record FIFO whose head entry is kept in a register.
// Latency: a push into an empty FIFO is visible at head one edge later.
// Backpressure: a push while full is accepted only when a pop happens on the same edge; otherwise it is ignored.
module result_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_nxt;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign rd_nxt  = rd_ptr + 1'b1;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_nxt;
      end

      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end

      // Keep head equal to the entry at the post-edge read pointer.
      // With one entry left, the next head can only be the data arriving now.
      if (do_pop) begin
        if (count > CW'(1)) begin
          head <= mem[rd_nxt];
        end else if (do_push) begin
          head <= push_data;
        end
      end else if (do_push && (count == '0)) begin
        head <= push_data;
      end
    end
  end

endmodule

// File: rtl/cpu_result_logger.sv
// Captures {sum, q} whenever either bus changes and streams each record out as 8 bytes.
// Latency: a change before edge E reaches out_data after E+1; stream throughput is 1 byte/cycle.
// Backpressure: out_data holds while out_ready is low; new records are dropped and counted once the FIFO is full.
module cpu_result_logger
  import cpu_logger_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              sum,
  input  logic [31:0]              q,
  input  logic                     capture_en,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [OVF_W-1:0]         overflow_cnt,
  output logic                     busy
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0] sum_prev;
  logic [31:0] q_prev;
  logic        change;
  logic        push_req;
  logic        push_ok;
  logic        pop;
  logic        fifo_nonempty;
  logic        handshake;
  logic        last_hs;
  record_t     fifo_head;
  record_t     shreg;
  logic [2:0]  byte_idx;
  ser_state_t  state;

  assign change        = (sum != sum_prev) || (q != q_prev);
  assign push_req      = change && capture_en;
  assign fifo_nonempty = (fifo_count != '0);
  assign handshake     = out_valid && out_ready;
  assign last_hs       = handshake && (byte_idx == LAST_BYTE);
  assign pop           = fifo_nonempty && ((state == IDLE) || last_hs);
  // A full FIFO still takes the record when the serializer frees a slot on this edge.
  assign push_ok       = push_req && ((fifo_count != CW'(DEPTH)) || pop);
  assign busy          = (state != IDLE) || fifo_nonempty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_prev <= '0;
      q_prev   <= '0;
    end else begin
      sum_prev <= sum;
      q_prev   <= q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_cnt <= '0;
    end else if (push_req && !push_ok && (overflow_cnt != '1)) begin
      overflow_cnt <= overflow_cnt + 1'b1;
    end
  end

  result_fifo #(
    .WIDTH (RECORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_req),
    .push_data ({sum, q}),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      shreg     <= '0;
      byte_idx  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            shreg     <= fifo_head;
            byte_idx  <= '0;
            out_data  <= fifo_head[RECORD_W-1 -: 8];
            out_valid <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          if (handshake) begin
            if (byte_idx != LAST_BYTE) begin
              byte_idx <= byte_idx + 3'd1;
              shreg    <= {shreg[RECORD_W-9:0], 8'h00};
              out_data <= shreg[RECORD_W-9 -: 8];
            end else if (pop) begin
              shreg    <= fifo_head;
              byte_idx <= '0;
              out_data <= fifo_head[RECORD_W-1 -: 8];
            end else begin
              out_valid <= 1'b0;
              out_data  <= '0;
              state     <= IDLE;
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
